// File: rtl/mul_pkg.sv
// Shared types and constants for the sequential shift-add mantissa multiplier.
package mul_pkg;

   localparam int unsigned MUL_WIDTH_DEFAULT = 24;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } mul_state_t;

   // Step counter width: enough to count 0..WIDTH-1.
   function automatic int unsigned mul_cnt_width(input int unsigned width);
      return (width > 1) ? $clog2(width) : 1;
   endfunction

endpackage

// File: rtl/seq_mantissa_mul_if.sv
// Operand/result handshake bundle for seq_mantissa_mul.
interface seq_mantissa_mul_if
   import mul_pkg::*;
#(
   parameter int unsigned WIDTH = MUL_WIDTH_DEFAULT
);
   logic                 in_valid;
   logic                 in_ready;
   logic [WIDTH-1:0]     a;
   logic [WIDTH-1:0]     b;
   logic                 out_valid;
   logic                 out_ready;
   logic [2*WIDTH-1:0]   product;
   logic                 busy;

   modport master (
      output in_valid, a, b, out_ready,
      input  in_ready, out_valid, product, busy
   );

   modport slave (
      input  in_valid, a, b, out_ready,
      output in_ready, out_valid, product, busy
   );
endinterface

// File: rtl/mul_step.sv
// One radix-2 add-shift step: conditionally add M into the high half, then
// shift the (2*WIDTH+1)-bit {carry,hi,lo} right by one.
module mul_step #(
   parameter int unsigned WIDTH = 24
) (
   input  logic [WIDTH-1:0] p_hi,
   input  logic [WIDTH-1:0] p_lo,
   input  logic [WIDTH-1:0] m,
   output logic [WIDTH-1:0] nxt_hi,
   output logic [WIDTH-1:0] nxt_lo
);
   logic [WIDTH:0] sum;

   // Single adder; the carry lands in bit WIDTH and is shifted into nxt_hi's MSB.
   always_comb begin
      sum = {1'b0, p_hi} + (p_lo[0] ? {1'b0, m} : (WIDTH+1)'(0));
   end

   assign nxt_hi = sum[WIDTH:1];
   assign nxt_lo = {sum[0], p_lo[WIDTH-1:1]};
endmodule

// File: rtl/seq_mantissa_mul.sv
// Sequential radix-2 shift-add multiplier for unsigned mantissas.
// Optional feature macro: MUL_EARLY_EXIT_EN (zero operand skips straight to DONE).
module seq_mantissa_mul
   import mul_pkg::*;
#(
   parameter int unsigned WIDTH = MUL_WIDTH_DEFAULT
) (
   input  logic             clk,
   input  logic             rst_n,
   seq_mantissa_mul_if.slave bus
);
   localparam int unsigned CNT_W = mul_cnt_width(WIDTH);
   localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

   mul_state_t           state;
   logic [WIDTH-1:0]     p_hi;
   logic [WIDTH-1:0]     p_lo;
   logic [WIDTH-1:0]     m;
   logic [CNT_W-1:0]     cnt;
   logic                 out_valid_q;
   logic [2*WIDTH-1:0]   product_q;
   logic [WIDTH-1:0]     nxt_hi;
   logic [WIDTH-1:0]     nxt_lo;

   mul_step #(.WIDTH(WIDTH)) u_step (
      .p_hi   (p_hi),
      .p_lo   (p_lo),
      .m      (m),
      .nxt_hi (nxt_hi),
      .nxt_lo (nxt_lo)
   );

   // Handshake status is decoded from the registered state only.
   assign bus.in_ready  = (state == IDLE);
   assign bus.busy      = (state != IDLE);
   assign bus.out_valid = out_valid_q;
   assign bus.product   = product_q;

   // FSM, step counter and datapath registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= IDLE;
         out_valid_q <= 1'b0;
         product_q   <= '0;
         cnt         <= '0;
         p_hi        <= '0;
         p_lo        <= '0;
         m           <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_valid) begin
`ifdef MUL_EARLY_EXIT_EN
                  if ((bus.a == '0) || (bus.b == '0)) begin
                     state       <= DONE;
                     out_valid_q <= 1'b1;
                     product_q   <= '0;
                  end else
`endif
                  begin
                     p_hi  <= '0;
                     p_lo  <= bus.b;
                     m     <= bus.a;
                     cnt   <= '0;
                     state <= RUN;
                  end
               end
            end
            RUN: begin
               p_hi <= nxt_hi;
               p_lo <= nxt_lo;
               cnt  <= cnt + CNT_W'(1);
               if (cnt == LAST_STEP) begin
                  state       <= DONE;
                  out_valid_q <= 1'b1;
                  product_q   <= {nxt_hi, nxt_lo};
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  state       <= IDLE;
                  out_valid_q <= 1'b0;
               end
            end
            default: begin
               state       <= IDLE;
               out_valid_q <= 1'b0;
            end
         endcase
      end
   end
endmodule
